// File: rtl/keypad_scan_ctrl.sv
// Scans a 3x4 active-low matrix keypad one column per tick, debouncing both press and release.
// Accepted keys appear on key_code with a one-cycle key_valid strobe; key_held stays high until release.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_N     = DW'(DEBOUNCE);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD} state_e;

  state_e        state_q;
  logic [1:0]    c_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [DW-1:0] deb_q, deb_plus;
  logic [3:0]    cap_row_q;
  logic [3:0]    cap_code_q;
  logic [3:0]    key_code_q;
  logic          key_valid_q;
  logic          key_held_q;
  logic [2:0]    col_q;
  logic          tick;

  function automatic logic [1:0] next_col(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  function automatic logic [2:0] col_drive(input logic [1:0] c);
    return ~(3'b100 >> c);
  endfunction

  // Topmost pulled-low row wins when several keys share the scanned column.
  function automatic logic [3:0] key_map(input logic [3:0] r_pat, input logic [1:0] c);
    logic [1:0] r;
    logic [3:0] code;
    if (!r_pat[3])      r = 2'd0;
    else if (!r_pat[2]) r = 2'd1;
    else if (!r_pat[1]) r = 2'd2;
    else                r = 2'd3;
    if (r == 2'd3) begin
      case (c)
        2'd0:    code = 4'd10;
        2'd1:    code = 4'd0;
        default: code = 4'd11;
      endcase
    end else begin
      code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    end
    return code;
  endfunction

  always_comb begin
    tick       = en && (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    deb_plus   = deb_q + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SCAN;
      c_q         <= 2'd0;
      tick_cnt_q  <= '0;
      deb_q       <= '0;
      cap_row_q   <= 4'd0;
      cap_code_q  <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      col_q       <= 3'b011;
    end else if (!en) begin
      col_q       <= 3'b111;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      tick_cnt_q  <= tick_cnt_d;
      col_q       <= col_drive(c_q);
      if (tick) begin
        case (state_q)
          S_SCAN: begin
            if (row != 4'hF) begin
              cap_row_q  <= row;
              cap_code_q <= key_map(row, c_q);
              deb_q      <= '0;
              state_q    <= S_DEBOUNCE;
            end else begin
              c_q   <= next_col(c_q);
              col_q <= col_drive(next_col(c_q));
            end
          end
          S_DEBOUNCE: begin
            if (row == cap_row_q) begin
              if (deb_plus == DEB_N) begin
                key_code_q  <= cap_code_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                deb_q       <= '0;
                state_q     <= S_HELD;
              end else begin
                deb_q <= deb_plus;
              end
            end else begin
              state_q <= S_SCAN;
              c_q     <= next_col(c_q);
              col_q   <= col_drive(next_col(c_q));
            end
          end
          S_HELD: begin
            if (row == 4'hF) begin
              if (deb_plus == DEB_N) begin
                key_held_q <= 1'b0;
                deb_q      <= '0;
                state_q    <= S_SCAN;
                c_q        <= next_col(c_q);
                col_q      <= col_drive(next_col(c_q));
              end else begin
                deb_q <= deb_plus;
              end
            end else begin
              deb_q <= '0;
            end
          end
          default: state_q <= S_SCAN;
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, tick-level reference model and key_valid scoreboard.
module tb_keypad_scan_ctrl;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst(rst), .en(en), .row(row),
    .col(col), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Pressed switches, bit index = keypad_row*3 + keypad_column.
  logic [11:0] pressed = '0;
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && col[2-c] == 1'b0) row[3-r] = 1'b0;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { int code; int cyc; } exp_t;
  exp_t sb_q[$];

  int KEYS [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};

  // Reference model: phase 0 = looking, 1 = confirming a press, 2 = waiting for release.
  int         cyc = 0;
  bit         started = 0;
  int         m_cnt, m_c, m_phase, m_run, m_capcode, m_code, m_held;
  logic [3:0] m_cap;
  logic [2:0] m_col;

  always @(posedge clk) begin
    int r;
    cyc++;
    if (rst) begin
      started = 1; m_cnt = 0; m_c = 0; m_phase = 0; m_run = 0;
      m_cap = 4'h0; m_capcode = 0; m_code = 0; m_held = 0; m_col = 3'b011;
    end else if (!en) begin
      m_col = 3'b111;
    end else begin
      if (m_cnt == SCAN_DIV - 1) begin
        m_cnt = 0;
        if (m_phase == 0) begin
          if (row != 4'hF) begin
            r = 3;
            for (int k = 3; k >= 0; k--) if (row[3-k] == 1'b0) r = k;
            m_cap = row; m_capcode = KEYS[r][m_c]; m_run = 0; m_phase = 1;
          end else m_c = (m_c + 1) % 3;
        end else if (m_phase == 1) begin
          if (row == m_cap) begin
            m_run++;
            if (m_run == DEBOUNCE) begin
              m_code = m_capcode; m_held = 1; m_run = 0; m_phase = 2;
              sb_q.push_back('{code: m_capcode, cyc: cyc});
            end
          end else begin
            m_phase = 0; m_c = (m_c + 1) % 3;
          end
        end else begin
          if (row == 4'hF) begin
            m_run++;
            if (m_run == DEBOUNCE) begin
              m_held = 0; m_run = 0; m_phase = 0; m_c = (m_c + 1) % 3;
            end
          end else m_run = 0;
        end
      end else m_cnt++;
      m_col = ~(3'b100 >> m_c);
    end
  end

  // Monitor: per-cycle output comparison and key_valid scoreboard pops.
  initial forever begin
    @(posedge clk); #1;
    if (started) begin
      chk("col", 32'(col), 32'(m_col));
      chk("key_held", 32'(key_held), 32'(m_held));
      chk("key_code", 32'(key_code), 32'(m_code));
      if (key_valid !== 1'b0) begin
        if (sb_q.size() == 0) chk("unexpected_key_valid_pending", 0, 1);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("key_valid_code", 32'(key_code), 32'(e.code));
          chk("key_valid_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_detect(input string name);
    int n;
    n = 0;
    while (m_phase != 1 && n < 200) begin @(negedge clk); n++; end
    chk({name, "_detect_within_bound"}, 32'(m_phase), 1);
  endtask

  initial begin
    int k, dur;
    // Reset and column walk
    rst = 1'b1; en = 1'b1; pressed = '0;
    cycles(2);
    chk("rst_col", 32'(col), 3'b011);
    chk("rst_key_code", 32'(key_code), 0);
    chk("rst_key_valid", 32'(key_valid), 0);
    chk("rst_key_held", 32'(key_held), 0);
    rst = 1'b0;
    cycles(3); chk("walk_col0_hold", 32'(col), 3'b011);
    cycles(1); chk("walk_col1", 32'(col), 3'b101);
    cycles(4); chk("walk_col2", 32'(col), 3'b110);
    cycles(4); chk("walk_col0", 32'(col), 3'b011);

    // Clean press of key 5
    pressed = 12'(1) << (1*3 + 1);
    cycles(40);
    chk("key5_held", 32'(key_held), 1);
    chk("key5_code", 32'(key_code), 5);
    pressed = '0;
    cycles(40);
    chk("key5_released", 32'(key_held), 0);

    // Bounce on key 9: only two confirming ticks
    pressed = 12'(1) << (2*3 + 2);
    wait_detect("key9");
    cycles(9);
    pressed = '0;
    cycles(40);
    chk("bounce_code_kept", 32'(key_code), 5);
    chk("bounce_no_held", 32'(key_held), 0);

    // Long hold of key 0 then release
    pressed = 12'(1) << (3*3 + 1);
    cycles(100);
    chk("key0_held", 32'(key_held), 1);
    chk("key0_code", 32'(key_code), 0);
    pressed = '0;
    cycles(40);
    chk("key0_released", 32'(key_held), 0);

    // Two keys in column 2 plus an enable gap mid-confirmation
    pressed = (12'(1) << (0*3 + 2)) | (12'(1) << (3*3 + 2));
    wait_detect("multi");
    cycles(2);
    en = 1'b0;
    cycles(3);
    chk("en_off_col", 32'(col), 3'b111);
    cycles(17);
    en = 1'b1;
    cycles(40);
    chk("multi_code", 32'(key_code), 3);
    pressed = '0;
    cycles(40);

    // Reset in the middle of confirming key 7
    pressed = 12'(1) << (2*3 + 0);
    wait_detect("key7");
    cycles(2);
    rst = 1'b1;
    cycles(1);
    chk("midrst_col", 32'(col), 3'b011);
    chk("midrst_key_valid", 32'(key_valid), 0);
    chk("midrst_key_held", 32'(key_held), 0);
    chk("midrst_key_code", 32'(key_code), 0);
    rst = 1'b0;
    pressed = '0;
    cycles(30);

    // Randomized presses, chords and enable dropouts
    for (int i = 0; i < 25; i++) begin
      k = $urandom_range(0, 11);
      pressed = 12'(1) << k;
      if ($urandom_range(0, 3) == 0) pressed = pressed | (12'(1) << $urandom_range(0, 11));
      dur = $urandom_range(4, 70);
      for (int t = 0; t < dur; t++) begin
        @(negedge clk);
        if ($urandom_range(0, 15) == 0) en = ~en;
      end
      en = 1'b1;
      pressed = '0;
      cycles($urandom_range(10, 50));
    end

    pressed = '0; en = 1'b1;
    cycles(80);
    chk("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Sequencing controller for the 3-column x 4-row matrix keypad on the lab board.
- Drives the column lines one at a time and samples the active-low row lines.
- Debounces both press and release.
- Emits a 4-bit key code with a one-cycle valid strobe and a held flag.
- Consumers are the LED-matrix and 7-segment display logic.

Parameters:
SCAN_DIV, 50000, clk cycles per scan tick (column dwell time); minimum 2.
DEBOUNCE, 4, consecutive matching ticks required to accept a press or a release; minimum 1.

Ports:
clk  in  1  system clock; the only clock in the block.
rst  in  1  synchronous reset, active-high.
en  in  1  scan enable; 0 freezes state and counters.
row  in  4  keypad rows, active-low; row[3] = top row (row 0), row[0] = bottom row (row 3).
col  out  3  column drive, active-low one-hot; col[2] = left column (col 0), col[0] = right column (col 2).
key_code  out  4  last accepted key code.
key_valid  out  1  one-cycle pulse when a new key is accepted.
key_held  out  1  high while an accepted key is still pressed.

Behaviour:
Reset (rst=1 at a clk edge):
- state=SCAN, column index c=0, col=3'b011.
- Tick counter, debounce counter, captured row pattern and key_code all cleared to 0.
- key_valid=0, key_held=0.
- rst has priority over everything, including mid-DEBOUNCE or HELD.

Tick generation:
- Counter runs 0..SCAN_DIV-1 while en=1 and wraps; tick=1 for the one cycle the count equals SCAN_DIV-1.
- en=0: counter, state, c and debounce counters hold; key_valid forced 0; col driven 3'b111.
- Column output: col = ~(3'b100 >> c), registered. Changes of c take effect the cycle after the tick.

Row decode:
- Pressed row r = the highest-priority zero in row, priority row[3] > row[2] > row[1] > row[0].
- row==4'b1111 means no key pressed.

Key code mapping (row r, column c):
- r0: 1, 2, 3
- r1: 4, 5, 6
- r2: 7, 8, 9
- r3: 10 (*), 0, 11 (#)

State SCAN:
- On tick with row != 1111: capture the row pattern and the decoded code, clear the debounce counter, go to DEBOUNCE. c is not advanced.
- On tick with row == 1111: c advances 0->1->2->0.

State DEBOUNCE:
- On each tick, if row equals the captured pattern, increment the debounce counter.
- When the counter reaches DEBOUNCE: key_code<=captured code, key_valid=1 for exactly one cycle (the cycle after that tick), key_held<=1, go to HELD, clear the counter.
- On a tick with a mismatch: no strobe, return to SCAN, advance c.

State HELD:
- col stays on column c.
- On each tick, if row==1111 increment the release counter, else clear it.
- When the release counter reaches DEBOUNCE: key_held<=0, go to SCAN, advance c.
- No further key_valid while in HELD, even if the row pattern changes. key_code holds its value.

Latency: a stable press is reported on key_valid exactly 1 cycle after the DEBOUNCE-th tick following the detecting tick.

Test Plan:
1. Reset: rst=1 for 2 cycles, then rst=0, en=1, row=1111 -> col=3'b011 during reset; key_code=0, key_valid=0, key_held=0; col then cycles 011->101->110->011, each step SCAN_DIV cycles apart.
2. Clean press: SCAN_DIV=4, DEBOUNCE=3; keypad model pulls row[2] low only while col[1]=0 (key 5); held 40 cycles -> exactly one key_valid pulse with key_code=5, 1 cycle after the 3rd tick following detection; key_held=1.
3. Bounce rejection: key 9 (row[1] with col[0]=0) pressed for only 2 ticks after detection, then released -> no key_valid; key_code unchanged; scan resumes from column 0.
4. Hold and release: key 0 (row[0] with col[1]=0) held 100 cycles, then released -> a single key_valid with code 0; key_held drops 1 cycle after the 3rd consecutive released tick; col resumes at 3'b110.
5. Multi-key and enable: rows 3 and 0 (row[3] and row[0]) pressed together in column 2 -> key_code=3. Then en=0 for 20 cycles mid-DEBOUNCE -> col=111, no strobe; debounce resumes and completes after en returns to 1.
6. Reset mid-operation: rst=1 while in DEBOUNCE with key 7 -> next cycle col=011, key_valid=0, key_held=0, key_code=0; no strobe for the interrupted press.
